// File: rtl/switch_fabric_pkg.sv
// Shared switch-fabric types: port index, invalid-port marker, arbiter state
// encoding and the round-robin pointer advance helper.
package switch_fabric_pkg;

  localparam int PORT_W = 5;

  typedef logic [PORT_W-1:0] port_t;

  localparam port_t INVALID_PORT = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Pointer position just after port p, wrapping after the last source.
  function automatic port_t next_port(input port_t p, input int num_src);
    return (p == port_t'(num_src - 1)) ? '0 : p + port_t'(1);
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Rotating-priority selector: lowest requester at or above rr_ptr_i wins,
// otherwise the lowest requester overall. Purely combinational.
module round_robin_picker
  import switch_fabric_pkg::*;
#(
  parameter int NUM_SRC = 28
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  port_t              rr_ptr_i,
  output logic [NUM_SRC-1:0] onehot_o,
  output port_t              idx_o
);

  logic  hi_found;
  port_t hi_idx;
  port_t lo_idx;

  // Descending scan so the last hit written is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = INVALID_PORT;
    lo_idx   = INVALID_PORT;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = port_t'(i);
        if (port_t'(i) >= rr_ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = port_t'(i);
        end
      end
    end
  end

  always_comb begin
    idx_o    = hi_found ? hi_idx : lo_idx;
    onehot_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      onehot_o[i] = (port_t'(i) == idx_o);
    end
  end

endmodule

// File: rtl/fabric_output_arbiter.sv
// Per-output-port arbiter: grants one source at a time for a whole frame,
// releasing on the granted source's last word or after an idle timeout.
module fabric_output_arbiter
  import switch_fabric_pkg::*;
#(
  parameter int NUM_SRC        = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [NUM_SRC-1:0] src_last,
  input  logic               out_ready,
  output logic [NUM_SRC-1:0] grant,
  output port_t              grant_id,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output arb_state_t         state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  port_t              grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               timeout_err_q, timeout_err_d;
  port_t              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic [NUM_SRC-1:0] pick_onehot;
  port_t              pick_idx;
  logic               start;
  logic               g_valid;
  logic               g_last;
  logic               timeout_hit;

  round_robin_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  // Handshake: src_last[i] means something only with src_valid[i], and only
  // the granted source is looked at; out_ready is a level meaning "room for one
  // maximum-size frame" and is consulted only when choosing a new winner.
  assign start       = out_ready && (|req);
  assign g_valid     = |(src_valid & grant_q);
  assign g_last      = |(src_valid & src_last & grant_q);
  assign timeout_hit = !g_valid && (idle_cnt_q == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_id_q    <= INVALID_PORT;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FWD;
      ST_FWD:  if (g_last || timeout_hit) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_d    = '0;
        grant_id_d = INVALID_PORT;
        busy_d     = 1'b0;
        idle_cnt_d = '0;
        if (start) begin
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
        end
      end
      ST_FWD: begin
        if (g_last || timeout_hit) begin
          // Last word beats a coincident timeout.
          grant_d       = '0;
          grant_id_d    = INVALID_PORT;
          busy_d        = 1'b0;
          frame_done_d  = g_last;
          timeout_err_d = !g_last;
          rr_ptr_d      = next_port(grant_id_q, NUM_SRC);
          idle_cnt_d    = '0;
        end else if (g_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = INVALID_PORT;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fabric_output_arbiter.sv
// Randomized scoreboard bench for fabric_output_arbiter with a queue-based
// round-robin reference model and a decoupled negedge monitor.
`timescale 1ns/100ps
module tb_fabric_output_arbiter;
  import switch_fabric_pkg::*;

  localparam int N   = 28;
  localparam int TMO = 16;
  localparam logic [1:0] END_DONE = 2'b01;
  localparam logic [1:0] END_TMO  = 2'b10;

  typedef logic [N-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  vec_t       req, src_valid, src_last;
  logic       out_ready;
  vec_t       grant;
  port_t      grant_id;
  logic       busy, frame_done, timeout_err;
  arb_state_t state_dbg;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_ptr = 0;
  bit hold_req_g = 1'b0;
  bit ready_low_g = 1'b0;

  // grants: {cycle[26:0], source[4:0]}; ends: {cycle[29:0], kind[1:0]}
  logic [31:0] exp_grant_q[$];
  logic [31:0] exp_end_q[$];

  fabric_output_arbiter #(
    .NUM_SRC        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #3.2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference winner: walk the sources starting at the pointer, wrapping once.
  function automatic int model_pick(input vec_t m, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic vec_t rand_mask();
    vec_t m;
    int   b;
    if ($urandom_range(1, 0) == 1) m = vec_t'($urandom);
    else begin
      m = '0;
      repeat ($urandom_range(3, 1)) begin
        b = $urandom_range(N - 1, 0);
        m[b] = 1'b1;
      end
    end
    if (m == '0) m[0] = 1'b1;
    return m;
  endfunction

  task automatic noise(input vec_t mask);
    req       = hold_req_g ? mask : vec_t'($urandom);
    out_ready = 1'($urandom);
    src_valid = vec_t'($urandom);
    src_last  = vec_t'($urandom);
  endtask

  task automatic do_reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'(INVALID_PORT));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    req = '0; src_valid = '0; src_last = '0; out_ready = 1'b0;
    wait_cycle();
    wait_cycle();
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // One arbitration: hold cycles with no grant possible, request, then drive
  // the winner's words until last or timeout (or abort with reset).
  task automatic run_txn(input vec_t mask, input int hold, input int nwords,
                         input int first_gap, input int max_gap,
                         input bit send_last, input int abort_at);
    int w, idle_run, sent, gap, fwd_cyc;
    bit v, l, ended;
    for (int h = 0; h < hold; h++) begin
      src_valid = vec_t'($urandom);
      src_last  = vec_t'($urandom);
      if (ready_low_g || $urandom_range(1, 0) == 1) begin
        req = mask; out_ready = 1'b0;
      end else begin
        req = '0; out_ready = 1'($urandom);
      end
      wait_cycle();
    end
    req = mask;
    out_ready = 1'b1;
    w = model_pick(mask, model_ptr);
    exp_grant_q.push_back({27'(cyc + 1), 5'(w)});
    wait_cycle();
    idle_run = 0; sent = 0; gap = first_gap; fwd_cyc = 0; ended = 1'b0;
    while (!ended) begin
      if (fwd_cyc == abort_at) begin
        do_reset_pulse();
        return;
      end
      v = 1'b0;
      if (sent < nwords) begin
        if (gap > 0) gap--;
        else v = 1'b1;
      end
      l = v && send_last && (sent == nwords - 1);
      noise(mask);
      src_valid[w] = v;
      if (v) src_last[w] = l;
      if (l) begin
        exp_end_q.push_back({30'(cyc + 1), END_DONE});
        ended = 1'b1;
      end else if (v) begin
        idle_run = 0;
        sent++;
        gap = $urandom_range(max_gap, 0);
      end else begin
        idle_run++;
        if (idle_run == TMO) begin
          exp_end_q.push_back({30'(cyc + 1), END_TMO});
          ended = 1'b1;
        end
      end
      if (ended) model_ptr = (w + 1) % N;
      fwd_cyc++;
      wait_cycle();
    end
    noise(mask);
    wait_cycle();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_busy = 1'b0;
  vec_t        prev_grant = '0;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy  = 1'b0;
      prev_grant = '0;
    end else begin
      while (exp_grant_q.size() > 0 && int'(exp_grant_q[0][31:5]) < cyc) begin
        mon_e = exp_grant_q.pop_front();
        n_vec++; n_fail++;
        $display("FAIL grant_missing: no grant seen, expected source %0d at cycle %0d", mon_e[4:0], mon_e[31:5]);
      end
      while (exp_end_q.size() > 0 && int'(exp_end_q[0][31:2]) < cyc) begin
        mon_e = exp_end_q.pop_front();
        n_vec++; n_fail++;
        $display("FAIL end_missing: no pulse seen, expected kind %0d at cycle %0d", mon_e[1:0], mon_e[31:2]);
      end
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
      chk("pulse_exclusive", 32'(frame_done && timeout_err), 32'd0);
      if (!busy) chk("idle_grant_id", 32'(grant_id), 32'(INVALID_PORT));
      if (busy && prev_busy) chk("grant_held", 32'(grant), 32'(prev_grant));
      if (busy && !prev_busy) begin
        if (exp_grant_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL grant_unexpected: got source %0d, expected no grant (cycle %0d)", grant_id, cyc);
        end else begin
          mon_e = exp_grant_q.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(mon_e[31:5]));
          chk("grant_id", 32'(grant_id), 32'(mon_e[4:0]));
          chk("grant_vector", 32'(grant), 32'd1 << mon_e[4:0]);
        end
      end
      if (frame_done || timeout_err) begin
        if (exp_end_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL end_unexpected: got done=%0b timeout=%0b, expected none (cycle %0d)", frame_done, timeout_err, cyc);
        end else begin
          mon_e = exp_end_q.pop_front();
          chk("end_cycle", 32'(cyc), 32'(mon_e[31:2]));
          chk("end_kind", 32'({timeout_err, frame_done}), 32'(mon_e[1:0]));
        end
        chk("end_grant_cleared", 32'(grant), 32'd0);
      end
      prev_busy  = busy;
      prev_grant = grant;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t m;
    rst_n = 1'b0; req = '0; src_valid = '0; src_last = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'(INVALID_PORT));
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;

    // sources 0 and 2: first grant 0, then pointer 1 selects 2
    run_txn(vec_t'(5), 0, 1, 0, 0, 1'b1, -1);
    run_txn(vec_t'(5), 0, 1, 0, 0, 1'b1, -1);

    // reset in the middle of a forward, pointer returns to 0
    run_txn(rand_mask(), 0, 6, 0, 0, 1'b1, 3);

    // every source requesting, single-word frames: 0..27 then 0
    hold_req_g = 1'b1;
    for (int i = 0; i <= N; i++) run_txn('1, 0, 1, 0, 0, 1'b1, -1);
    hold_req_g = 1'b0;

    // pointer wrap from source 27, then {27,3} selects 3
    m = '0; m[27] = 1'b1;
    run_txn(m, 0, 2, 0, 1, 1'b1, -1);
    m[3] = 1'b1;
    run_txn(m, 0, 1, 0, 0, 1'b1, -1);

    // timeout boundaries
    run_txn(rand_mask(), 0, 0, 0, 0, 1'b1, -1);
    run_txn(rand_mask(), 0, 1, 15, 0, 1'b1, -1);
    run_txn(rand_mask(), 0, 1, 16, 0, 1'b1, -1);
    run_txn(rand_mask(), 0, 3, 14, 15, 1'b1, -1);

    // out_ready low with requests pending
    ready_low_g = 1'b1;
    run_txn(rand_mask(), $urandom_range(6, 3), 2, 1, 2, 1'b1, -1);
    ready_low_g = 1'b0;

    for (int t = 0; t < 60; t++) begin
      run_txn(rand_mask(), $urandom_range(3, 0), $urandom_range(4, 1),
              $urandom_range(3, 0), ($urandom_range(1, 0) == 1) ? 18 : 3,
              ($urandom_range(9, 0) != 0), -1);
    end

    req = '0; src_valid = '0; src_last = '0; out_ready = 1'b0;
    repeat (30) wait_cycle();
    chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    chk("end_queue_drained", 32'(exp_end_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
